// File: rtl/sopc_bus_pkg.sv
// Shared definitions for the SoPC data-side bus: FSM encodings, default geometry and the slave map.
// Optional build macro used by sopc_data_bus: SOPC_BUS_TIMEOUT_EN.
package sopc_bus_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_AW      = 32;
    localparam int DEF_NSLV    = 4;
    localparam int DEF_IDX_W   = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_e;

    // Slave channel numbers as seen in the top address nibble.
    localparam int SLV_RAM   = 0;
    localparam int SLV_TIMER = 1;
    localparam int SLV_UART  = 2;
    localparam int SLV_GPIO  = 3;

endpackage

// File: rtl/sopc_addr_decoder.sv
// Address decoder: upper IDX_W address bits select the slave; hit is low for unmapped indices.
module sopc_addr_decoder #(
    parameter int AW    = 32,
    parameter int IDX_W = 4,
    parameter int NSLV  = 4
) (
    input  logic [AW-1:0]    addr,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    logic [AW-IDX_W-1:0] unused_low;

    assign idx        = addr[AW-1 -: IDX_W];
    assign hit        = (32'(idx) < 32'(NSLV));
    assign unused_low = addr[AW-IDX_W-1:0];

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect: one CPU master fanned out to NSLV slaves with ack handshake and stall.
// Build macro SOPC_BUS_TIMEOUT_EN adds a WAIT-state watchdog that turns a silent slave into a bus error.
module sopc_data_bus
    import sopc_bus_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int NSLV    = DEF_NSLV,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_ce_i,
    input  logic                m_we_i,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW/8-1:0]     m_sel_i,
    input  logic [DW-1:0]       m_data_i,
    output logic [DW-1:0]       m_data_o,
    output logic                m_stall_o,
    output logic                m_err_o,
    output logic [NSLV-1:0]     s_ce_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_data_o,
    input  logic [NSLV*DW-1:0]  s_data_i,
    input  logic [NSLV-1:0]     s_ack_i
);

    bus_state_e        state_reg;
    bus_state_e        state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  dec_idx;
    logic              dec_hit;
    logic [NSLV-1:0]   ce_onehot;
    logic [NSLV-1:0]   sel_match;
    logic              ack_hit;
    logic              timeout_hit;
    logic [DW-1:0]     rd_data;

    sopc_addr_decoder #(
        .AW    (AW),
        .IDX_W (IDX_W),
        .NSLV  (NSLV)
    ) u_dec (
        .addr (m_addr_i),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    // ce_onehot selects the slave of the incoming request, sel_match the slave of the access in flight.
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
            assign ce_onehot[gi] = (dec_idx == IDX_W'(gi));
            assign sel_match[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign ack_hit = |(s_ack_i & sel_match);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_match[k]) begin
                rd_data = rd_data | s_data_i[k*DW +: DW];
            end
        end
    end

`ifdef SOPC_BUS_TIMEOUT_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_WAIT && !ack_hit) begin
            cnt_reg <= cnt_reg + 16'd1;
        end else begin
            cnt_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == ST_WAIT) && (cnt_reg == 16'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An ack in the last allowed WAIT cycle takes priority over the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (m_ce_i) begin
                    state_next = dec_hit ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                if (ack_hit) begin
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_stall_o = 1'b0;
        if (!rst) begin
            m_stall_o = (state_reg == ST_IDLE && m_ce_i) || (state_reg == ST_WAIT);
        end
    end

    // Registered slave-side outputs and CPU return path; m_data_o is non-zero only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg  <= '0;
            s_ce_o   <= '0;
            s_we_o   <= 1'b0;
            s_addr_o <= '0;
            s_sel_o  <= '0;
            s_data_o <= '0;
            m_data_o <= '0;
            m_err_o  <= 1'b0;
        end else begin
            m_data_o <= '0;
            m_err_o  <= (state_next == ST_ERR);
            case (state_reg)
                ST_IDLE: begin
                    if (m_ce_i && dec_hit) begin
                        idx_reg  <= dec_idx;
                        s_ce_o   <= ce_onehot;
                        s_we_o   <= m_we_i;
                        s_addr_o <= m_addr_i;
                        s_sel_o  <= m_sel_i;
                        s_data_o <= m_data_i;
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        s_ce_o <= '0;
                        if (!s_we_o) begin
                            m_data_o <= rd_data;
                        end
                    end else if (timeout_hit) begin
                        s_ce_o <= '0;
                    end
                end
                default: begin
                    s_ce_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_data_bus.sv
// Randomized bench for sopc_data_bus: bench-side slaves with word memories act as the reference model.
// Expects the timeout watchdog behaviour when built with SOPC_BUS_TIMEOUT_EN.
module tb_sopc_data_bus;
    import sopc_bus_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NSLV  = 4;
    localparam int IDX_W = 4;
    localparam int TMO   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               m_ce_i;
    logic               m_we_i;
    logic [AW-1:0]      m_addr_i;
    logic [DW/8-1:0]    m_sel_i;
    logic [DW-1:0]      m_data_i;
    logic [DW-1:0]      m_data_o;
    logic               m_stall_o;
    logic               m_err_o;
    logic [NSLV-1:0]    s_ce_o;
    logic               s_we_o;
    logic [AW-1:0]      s_addr_o;
    logic [DW/8-1:0]    s_sel_o;
    logic [DW-1:0]      s_data_o;
    logic [NSLV*DW-1:0] s_data_i;
    logic [NSLV-1:0]    s_ack_i;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    logic [DW-1:0] mem [NSLV][16];

    sopc_data_bus #(
        .DW      (DW),
        .AW      (AW),
        .NSLV    (NSLV),
        .IDX_W   (IDX_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_ce_i    (m_ce_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_sel_i   (m_sel_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_stall_o (m_stall_o),
        .m_err_o   (m_err_o),
        .s_ce_o    (s_ce_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_sel_o   (s_sel_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_slave_data(input int slv, input logic [DW-1:0] word);
        for (int k = 0; k < NSLV; k++) begin
            s_data_i[k*DW +: DW] = $urandom;
        end
        if (slv >= 0) begin
            s_data_i[slv*DW +: DW] = word;
        end
    endtask

    // One CPU access; the bench-side slave acks in WAIT cycle number 'delay' (0 = first WAIT cycle).
    task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW/8-1:0] sel,
                             input logic [DW-1:0] wdata, input int delay, input logic stray);
        int            slv;
        int            word;
        logic [DW-1:0] exp_rd;
        logic [NSLV-1:0] onehot;
        slv  = int'(addr[AW-1 -: IDX_W]);
        word = int'(addr[5:2]);
        @(posedge clk); #1;
        m_ce_i   = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_sel_i  = sel;
        m_data_i = wdata;
        s_ack_i  = '0;
        fill_slave_data(-1, '0);
        @(negedge clk);
        check_val("stall_request", m_stall_o, 1);
        if (slv >= NSLV) begin
            check_val("unmapped_no_ce", s_ce_o, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check_val("unmapped_err", m_err_o, 1);
            check_val("unmapped_stall", m_stall_o, 0);
            check_val("unmapped_ce", s_ce_o, 0);
            check_val("unmapped_data", m_data_o, 0);
        end else begin
            exp_rd = mem[slv][word];
            onehot = NSLV'(1) << slv;
            for (int w = 0; w <= delay; w++) begin
                @(posedge clk); #1;
                fill_slave_data(slv, exp_rd);
                if (w == delay) begin
                    s_ack_i = onehot;
                end else if (stray) begin
                    s_ack_i = NSLV'($urandom) & ~onehot;
                end else begin
                    s_ack_i = '0;
                end
                @(negedge clk);
                check_val("wait_stall", m_stall_o, 1);
                check_val("wait_ce", s_ce_o, onehot);
                check_val("wait_we", s_we_o, we);
                check_val("wait_addr", s_addr_o, addr);
                check_val("wait_sel", s_sel_o, sel);
                check_val("wait_wdata", s_data_o, wdata);
                check_val("wait_err", m_err_o, 0);
            end
            if (we) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (sel[b]) mem[slv][word][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
            @(posedge clk); #1;
            s_ack_i = '0;
            @(negedge clk);
            check_val("done_stall", m_stall_o, 0);
            check_val("done_err", m_err_o, 0);
            check_val("done_ce", s_ce_o, 0);
            check_val("done_data", m_data_o, we ? '0 : exp_rd);
        end
        n_txn++;
        $display("txn %0d: %s addr=%08h sel=%b slave=%0d delay=%0d stray=%0b", n_txn,
                 we ? "WR" : "RD", addr, sel, slv, delay, stray);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        m_ce_i  = 1'b0;
        s_ack_i = NSLV'($urandom);
        @(negedge clk);
        check_val("idle_stall", m_stall_o, 0);
        check_val("idle_ce", s_ce_o, 0);
        @(posedge clk); #1;
        s_ack_i = '0;
        @(negedge clk);
        check_val("idle_data", m_data_o, 0);
        check_val("idle_err", m_err_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            slv;
        for (int s = 0; s < NSLV; s++) begin
            for (int w = 0; w < 16; w++) mem[s][w] = $urandom;
        end
        mem[SLV_RAM][4] = 32'h1234_5678;

        rst      = 1'b1;
        m_ce_i   = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = '0;
        m_sel_i  = '0;
        m_data_i = '0;
        s_ack_i  = '0;
        s_data_i = '0;
        @(negedge clk);
        check_val("rst_stall_forced", m_stall_o, 0);
        @(posedge clk); #1;
        m_ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ce", s_ce_o, 0);
        check_val("rst_we", s_we_o, 0);
        check_val("rst_addr", s_addr_o, 0);
        check_val("rst_sel", s_sel_o, 0);
        check_val("rst_wdata", s_data_o, 0);
        check_val("rst_mdata", m_data_o, 0);
        check_val("rst_err", m_err_o, 0);
        check_val("rst_stall", m_stall_o, 0);

        // Directed cases: zero-wait read, wait-state write, unmapped read.
        do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 1'b0);
        do_access(1'b1, 32'h1000_0004, 4'b0011, 32'hDEAD_BEEF, 2, 1'b0);
        do_access(1'b0, 32'hF000_0000, 4'hF, 32'h0, 0, 1'b0);
        do_access(1'b0, 32'h1000_0004, 4'hF, 32'h0, 1, 1'b1);
        idle_cycle();

        // Slave 2 never acks.
        @(posedge clk); #1;
        m_ce_i   = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = 32'h2000_0000;
        m_sel_i  = 4'hF;
        s_ack_i  = '0;
        @(negedge clk);
        check_val("tmo_req_stall", m_stall_o, 1);
`ifdef SOPC_BUS_TIMEOUT_EN
        for (int w = 0; w < TMO; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("tmo_wait_stall", m_stall_o, 1);
            check_val("tmo_wait_ce", s_ce_o, 4'b0100);
            check_val("tmo_wait_err", m_err_o, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_val("tmo_err", m_err_o, 1);
        check_val("tmo_err_stall", m_stall_o, 0);
        check_val("tmo_err_ce", s_ce_o, 0);
        check_val("tmo_err_data", m_data_o, 0);
`else
        for (int w = 0; w < 120; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("notmo_stall", m_stall_o, 1);
            check_val("notmo_ce", s_ce_o, 4'b0100);
            check_val("notmo_err", m_err_o, 0);
        end
        @(posedge clk); #1;
        fill_slave_data(SLV_UART, mem[SLV_UART][0]);
        s_ack_i = 4'b0100;
        @(negedge clk);
        @(posedge clk); #1;
        s_ack_i = '0;
        @(negedge clk);
        check_val("notmo_done_stall", m_stall_o, 0);
        check_val("notmo_done_data", m_data_o, mem[SLV_UART][0]);
`endif
        @(posedge clk); #1;
        m_ce_i = 1'b0;
        @(negedge clk);
        check_val("tmo_after_stall", m_stall_o, 0);
        $display("txn %0d: RD addr=20000000 slave=2 no-ack", ++n_txn);

        // Stray ack from slave 3 while slave 0 is selected, then reset mid-WAIT.
        @(posedge clk); #1;
        m_ce_i   = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = 32'h0000_0020;
        @(negedge clk);
        @(posedge clk); #1;
        s_ack_i = 4'b1000;
        @(negedge clk);
        check_val("stray_stall", m_stall_o, 1);
        check_val("stray_ce", s_ce_o, 4'b0001);
        @(posedge clk); #1;
        s_ack_i = '0;
        rst     = 1'b1;
        @(negedge clk);
        check_val("midrst_stall", m_stall_o, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        m_ce_i = 1'b0;
        fill_slave_data(SLV_RAM, 32'hCAFE_F00D);
        s_ack_i = 4'b0001;
        @(negedge clk);
        check_val("postrst_ce", s_ce_o, 0);
        check_val("postrst_stall", m_stall_o, 0);
        @(posedge clk); #1;
        s_ack_i = '0;
        @(negedge clk);
        check_val("late_ack_data", m_data_o, 0);
        check_val("late_ack_err", m_err_o, 0);
        check_val("late_ack_ce", s_ce_o, 0);
        $display("txn %0d: RD addr=00000020 slave=0 aborted by reset", ++n_txn);

        // Randomized traffic, mostly back-to-back.
        for (int t = 0; t < 40; t++) begin
            slv = int'($urandom_range(0, 5));
            if (slv >= NSLV) slv = int'($urandom_range(NSLV, 15));
            a = {4'(slv), 22'd0, 4'($urandom), 2'($urandom)};
            do_access(1'($urandom), a, 4'($urandom_range(1, 15)), $urandom,
                      int'($urandom_range(0, 4)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
